mc_main_control: RTL and testbench

- Multi-cycle main control FSM for the multi-cycle MIPS core.
- Sequences a shared-ALU, single-memory datapath: fetch, decode, execute, memory and writeback phases per instruction.
- Reuses the single-cycle opcode set: R-type, lw, sw, beq, bne, j, jal, addi.
- Waits on a memory-ready handshake and emits per-cycle datapath enables and mux selects.

---
 rtl/mc_main_control.sv | 169 ++++++++++++++++
 tb/tb_mc_main_control.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mc_main_control.sv
// mc_main_control: multi-cycle MIPS main control FSM (fetch/decode/execute/memory/writeback).
// Build option: define MC_PERF_CNT_EN to add cycle_cnt_o and instr_cnt_o performance counters.
// Ports:
//   clk_i, rst_ni (async active-low); opcode_i (IR[31:26]); zero_i (ALU zero); mem_ready_i (memory done)
//   enables: pc_write_o, ir_write_o, reg_write_o, mem_read_o, mem_write_o (all forced 0 while rst_ni=0)
//   selects: iord_o, reg_dst_o, mem_to_reg_o, alu_src_a_o, alu_src_b_o, alu_op_o, pc_source_o, al_o, ra_sel_o
//   status:  illegal_op_o (1-cycle pulse after an unknown opcode is decoded), state_o (debug)
// The PC increment (4) is supplied by the datapath when alu_src_b_o=01.
module mc_main_control #(
  parameter logic [4:0] RA_REG = 5'd31
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [5:0]  opcode_i,
  input  logic        zero_i,
  input  logic        mem_ready_i,
  output logic        pc_write_o,
  output logic        iord_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic        ir_write_o,
  output logic        reg_dst_o,
  output logic        mem_to_reg_o,
  output logic        reg_write_o,
  output logic        alu_src_a_o,
  output logic [1:0]  alu_src_b_o,
  output logic [1:0]  alu_op_o,
  output logic [1:0]  pc_source_o,
  output logic        al_o,
  output logic [4:0]  ra_sel_o,
  output logic        illegal_op_o,
`ifdef MC_PERF_CNT_EN
  output logic [31:0] cycle_cnt_o,
  output logic [31:0] instr_cnt_o,
`endif
  output logic [3:0]  state_o
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB,
    BRANCH, JUMP, ADDIEX, ADDIWB, JAL
  } state_e;
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_J = 6'b000010,
                         OP_JAL = 6'b000011, OP_ADDI = 6'b001000;
  state_e state_q, state_d;
  logic illegal_q, illegal_d;
  logic pcw, irw, rw, mr, mw;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end
  always_comb begin
    state_d      = FETCH;
    illegal_d    = 1'b0;
    pcw          = 1'b0;
    irw          = 1'b0;
    rw           = 1'b0;
    mr           = 1'b0;
    mw           = 1'b0;
    iord_o       = 1'b0;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = 2'b00;
    alu_op_o     = 2'b00;
    pc_source_o  = 2'b00;
    al_o         = 1'b0;
    case (state_q)
      FETCH: begin
        mr          = 1'b1;
        alu_src_b_o = 2'b01;
        pcw         = mem_ready_i;
        irw         = mem_ready_i;
        state_d     = mem_ready_i ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_b_o = 2'b11;
        case (opcode_i)
          OP_R:           state_d = EXEC;
          OP_LW, OP_SW:   state_d = MEMADR;
          OP_BEQ, OP_BNE: state_d = BRANCH;
          OP_J:           state_d = JUMP;
          OP_JAL:         state_d = JAL;
          OP_ADDI:        state_d = ADDIEX;
          default:        illegal_d = 1'b1;
        endcase
      end
      MEMADR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        state_d     = (opcode_i == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        mr      = 1'b1;
        iord_o  = 1'b1;
        state_d = mem_ready_i ? MEMWB : MEMRD;
      end
      MEMWB: begin
        rw           = 1'b1;
        mem_to_reg_o = 1'b1;
      end
      MEMWR: begin
        mw      = 1'b1;
        iord_o  = 1'b1;
        state_d = mem_ready_i ? FETCH : MEMWR;
      end
      EXEC: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = 2'b10;
        state_d     = ALUWB;
      end
      ALUWB: begin
        rw        = 1'b1;
        reg_dst_o = 1'b1;
      end
      BRANCH: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = 2'b01;
        pc_source_o = 2'b01;
        pcw         = (opcode_i == OP_BNE) ? ~zero_i : zero_i;
      end
      JUMP: begin
        pcw         = 1'b1;
        pc_source_o = 2'b10;
      end
      JAL: begin
        pcw         = 1'b1;
        rw          = 1'b1;
        al_o        = 1'b1;
        pc_source_o = 2'b10;
      end
      ADDIEX: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        state_d     = ADDIWB;
      end
      ADDIWB: rw = 1'b1;
      default: state_d = FETCH;
    endcase
  end
  // Enables are gated by reset so nothing writes while reset is held, whatever the state.
  assign pc_write_o   = pcw & rst_ni;
  assign ir_write_o   = irw & rst_ni;
  assign reg_write_o  = rw & rst_ni;
  assign mem_read_o   = mr & rst_ni;
  assign mem_write_o  = mw & rst_ni;
  assign ra_sel_o     = RA_REG;
  assign illegal_op_o = illegal_q;
  assign state_o      = state_q;
`ifdef MC_PERF_CNT_EN
  logic [31:0] cycle_cnt_q, instr_cnt_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_q + 32'd1;
      if (state_q != FETCH && state_d == FETCH) instr_cnt_q <= instr_cnt_q + 32'd1;
    end
  end
  assign cycle_cnt_o = cycle_cnt_q;
  assign instr_cnt_o = instr_cnt_q;
`endif
endmodule

// File: tb/tb_mc_main_control.sv
// tb_mc_main_control: self-checking bench for mc_main_control using per-instruction expected traces.
module tb_mc_main_control;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [5:0] opcode = '0;
  logic zero = 1'b0, mem_ready = 1'b0;
  logic pc_write, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
  logic alu_src_a, al, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [4:0] ra_sel;
  logic [3:0] state;
`ifdef MC_PERF_CNT_EN
  logic [31:0] cycle_cnt, instr_cnt;
`endif
  int vectors = 0, miscompares = 0, ninstr = 0, cyc = 0;
  logic pend_ill = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk or negedge rst_n) cyc <= !rst_n ? 0 : cyc + 1;
  mc_main_control dut (
    .clk_i(clk), .rst_ni(rst_n), .opcode_i(opcode), .zero_i(zero), .mem_ready_i(mem_ready),
    .pc_write_o(pc_write), .iord_o(iord), .mem_read_o(mem_read), .mem_write_o(mem_write),
    .ir_write_o(ir_write), .reg_dst_o(reg_dst), .mem_to_reg_o(mem_to_reg), .reg_write_o(reg_write),
    .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b), .alu_op_o(alu_op), .pc_source_o(pc_source),
    .al_o(al), .ra_sel_o(ra_sel), .illegal_op_o(illegal_op),
`ifdef MC_PERF_CNT_EN
    .cycle_cnt_o(cycle_cnt), .instr_cnt_o(instr_cnt),
`endif
    .state_o(state)
  );
  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100,
                         BNE = 6'b000101, J = 6'b000010, JAL = 6'b000011, ADDI = 6'b001000;
  // select vectors {iord, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source, al}
  localparam logic [10:0] S_F = 11'b0000_01_00_00_0, S_D = 11'b0000_11_00_00_0,
                          S_MA = 11'b0001_10_00_00_0, S_MEM = 11'b1000_00_00_00_0,
                          S_MWB = 11'b0010_00_00_00_0, S_EX = 11'b0001_00_10_00_0,
                          S_AWB = 11'b0100_00_00_00_0, S_BR = 11'b0001_00_01_01_0,
                          S_J = 11'b0000_00_00_10_0, S_JAL = 11'b0000_00_00_10_1,
                          S_AI = 11'b0001_10_00_00_0, S_0 = 11'b0;
  // en = {pc_write, ir_write, reg_write, mem_read, mem_write}; rdy: 0/1 forced, 2 = random
  typedef struct {
    logic [3:0]  st;
    logic [4:0]  en;
    logic [10:0] sel;
    logic [1:0]  rdy;
  } exp_t;
  function automatic exp_t mk(logic [3:0] st, logic [4:0] en, logic [10:0] sel, logic [1:0] rdy);
    exp_t e;
    e.st = st; e.en = en; e.sel = sel; e.rdy = rdy;
    return e;
  endfunction
  task automatic run_instr(input string tag, input logic [5:0] op, input int fw, input int mwt, input logic z);
    exp_t q[$];
    logic ill = 1'b0;
    logic [20:0] got, exp_v;
    for (int i = 0; i < fw; i++) q.push_back(mk(0, 5'b00010, S_F, 0));
    q.push_back(mk(0, 5'b11010, S_F, 1));
    q.push_back(mk(1, 5'b00000, S_D, 2));
    case (op)
      LW: begin
        q.push_back(mk(2, 5'b00000, S_MA, 2));
        for (int i = 0; i < mwt; i++) q.push_back(mk(3, 5'b00010, S_MEM, 0));
        q.push_back(mk(3, 5'b00010, S_MEM, 1));
        q.push_back(mk(4, 5'b00100, S_MWB, 2));
      end
      SW: begin
        q.push_back(mk(2, 5'b00000, S_MA, 2));
        for (int i = 0; i < mwt; i++) q.push_back(mk(5, 5'b00001, S_MEM, 0));
        q.push_back(mk(5, 5'b00001, S_MEM, 1));
      end
      R: begin
        q.push_back(mk(6, 5'b00000, S_EX, 2));
        q.push_back(mk(7, 5'b00100, S_AWB, 2));
      end
      BEQ:  q.push_back(mk(8, {z, 4'b0000}, S_BR, 2));
      BNE:  q.push_back(mk(8, {~z, 4'b0000}, S_BR, 2));
      J:    q.push_back(mk(9, 5'b10000, S_J, 2));
      JAL:  q.push_back(mk(12, 5'b10100, S_JAL, 2));
      ADDI: begin
        q.push_back(mk(10, 5'b00000, S_AI, 2));
        q.push_back(mk(11, 5'b00100, S_0, 2));
      end
      default: ill = 1'b1;
    endcase
    foreach (q[k]) begin
      @(negedge clk);
      opcode = op;
      zero = z;
      mem_ready = (q[k].rdy == 2'd2) ? 1'($urandom) : q[k].rdy[0];
      #1;
      exp_v = {q[k].st, q[k].en, q[k].sel, (k == 0) && pend_ill};
      got = {state, pc_write, ir_write, reg_write, mem_read, mem_write,
             iord, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source, al, illegal_op};
      vectors++;
      if (got !== exp_v) begin
        miscompares++;
        $display("FAIL %s op=%b cycle %0d: got st/en/sel/ill=%h required %h", tag, op, k, got, exp_v);
      end
    end
    pend_ill = ill;
    ninstr++;
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if ({state, pc_write, ir_write, reg_write, mem_read, mem_write, illegal_op} !== 10'b0) begin
      miscompares++;
      $display("FAIL reset_hold: got st=%0d en=%b%b%b%b%b ill=%b required all 0", state,
               pc_write, ir_write, reg_write, mem_read, mem_write, illegal_op);
    end
`ifdef MC_PERF_CNT_EN
    vectors++;
    if (cycle_cnt !== 32'd0 || instr_cnt !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_cnt: got cyc=%0d ins=%0d required 0 0", cycle_cnt, instr_cnt);
    end
`endif
    @(posedge clk);
    #1 rst_n = 1'b1;
    pend_ill = 1'b0;
    ninstr = 0;
    #1;
    vectors++;
    if ({state, pc_write, ir_write, reg_write, mem_read, mem_write} !== {4'd0, 5'b11010}) begin
      miscompares++;
      $display("FAIL reset_first_fetch: got st=%0d en=%b%b%b%b%b required 0 11010", state,
               pc_write, ir_write, reg_write, mem_read, mem_write);
    end
  endtask
  task automatic test_lw;
    run_instr("lw_wait2", LW, 0, 2, 1'b0);
  endtask
  task automatic test_branch;
    run_instr("beq_z1", BEQ, 0, 0, 1'b1);
    run_instr("beq_z0", BEQ, 0, 0, 1'b0);
    run_instr("bne_z0", BNE, 0, 0, 1'b0);
    run_instr("bne_z1", BNE, 1, 0, 1'b1);
  endtask
  task automatic test_jal;
    run_instr("jal", JAL, 0, 0, 1'b0);
    vectors++;
    if (ra_sel !== 5'd31) begin
      miscompares++;
      $display("FAIL ra_sel: got %0d required 31", ra_sel);
    end
  endtask
  task automatic test_illegal;
    run_instr("illegal", 6'b111111, 0, 0, 1'b0);
    run_instr("after_illegal", R, 0, 0, 1'b0);
    run_instr("illegal2", 6'b110001, 1, 0, 1'b0);
    run_instr("after_illegal2", ADDI, 2, 0, 1'b0);
  endtask
  task automatic test_back_to_back;
    run_instr("sw_wait0", SW, 0, 0, 1'b0);
    run_instr("sw_wait3", SW, 0, 3, 1'b0);
    run_instr("j", J, 0, 0, 1'b0);
    run_instr("addi", ADDI, 0, 0, 1'b0);
    run_instr("rtype", R, 0, 0, 1'b0);
  endtask
  task automatic test_random;
    logic [5:0] ops [8] = '{R, LW, SW, BEQ, BNE, J, JAL, ADDI};
    logic [5:0] op;
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 8) == 0) begin
        do op = 6'($urandom); while (op inside {R, LW, SW, BEQ, BNE, J, JAL, ADDI});
      end else op = ops[$urandom_range(0, 7)];
      run_instr("random", op, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom));
    end
    run_instr("random_tail", R, 0, 0, 1'b0);
`ifdef MC_PERF_CNT_EN
    @(negedge clk);
    vectors++;
    if (cycle_cnt !== 32'(cyc) || instr_cnt !== 32'(ninstr)) begin
      miscompares++;
      $display("FAIL perf_cnt: got cyc=%0d ins=%0d required %0d %0d", cycle_cnt, instr_cnt, cyc, ninstr);
    end
`endif
  endtask
  task automatic test_reset_midwrite;
    @(negedge clk);
    opcode = SW;
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if (state !== 4'd5 || mem_write !== 1'b1) begin
      miscompares++;
      $display("FAIL sw_wait: got st=%0d mem_write=%b required 5 1", state, mem_write);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (state !== 4'd0 || mem_write !== 1'b0 || reg_write !== 1'b0 || pc_write !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_midwrite: got st=%0d mw=%b rw=%b pcw=%b required 0 0 0 0",
               state, mem_write, reg_write, pc_write);
    end
`ifdef MC_PERF_CNT_EN
    vectors++;
    if (cycle_cnt !== 32'd0 || instr_cnt !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_midwrite_cnt: got cyc=%0d ins=%0d required 0 0", cycle_cnt, instr_cnt);
    end
`endif
    @(posedge clk);
    #1 rst_n = 1'b1;
    pend_ill = 1'b0;
    ninstr = 0;
    run_instr("post_reset_lw", LW, 0, 0, 1'b0);
  endtask
  initial begin
    test_reset;
    test_lw;
    test_branch;
    test_jal;
    test_illegal;
    test_back_to_back;
    test_random;
    test_reset_midwrite;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
